// File: rtl/wta_lif_array.sv
// wta_lif_array: winner-take-all array of leaky integrate-and-fire neurons with lateral inhibition and refractory periods
module wta_lif_array #(
  parameter int N_NEURONS = 4,
  parameter int W = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRACT = 2,
  localparam int IW = $clog2(N_NEURONS),
  localparam int RW = REFRACT > 0 ? $clog2(REFRACT + 1) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [N_NEURONS*W-1:0] current,
  input  logic [W-1:0]           threshold,
  input  logic [W-1:0]           inhibit,
  input  logic [IW-1:0]          probe_sel,
  output logic [N_NEURONS-1:0]   spike,
  output logic [IW-1:0]          winner,
  output logic                   winner_valid,
  output logic [W-1:0]           probe_state
);
  logic [N_NEURONS-1:0][W-1:0]  state;
  logic [N_NEURONS-1:0][RW-1:0] refr;
  logic [N_NEURONS-1:0][W+1:0]  raw;
  logic [N_NEURONS-1:0][W-1:0]  nxt;
  logic [N_NEURONS-1:0][W-1:0]  dec;
  logic [N_NEURONS-1:0]         cand;
  logic                         found;
  logic [IW-1:0]                best;
  logic [W-1:0]                 best_v;
  always_comb begin
    found = 1'b0;
    best = '0;
    best_v = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      raw[i] = (W+2)'(state[i]) - (W+2)'(state[i] >> LEAK_SHIFT) + (W+2)'(current[i*W +: W]);
      nxt[i] = |raw[i][W+1:W] ? '1 : raw[i][W-1:0];
      dec[i] = nxt[i] > inhibit ? nxt[i] - inhibit : '0;
      cand[i] = refr[i] == '0 && nxt[i] >= threshold;
      if (cand[i] && (!found || nxt[i] > best_v)) begin
        found = 1'b1;
        best = IW'(i);
        best_v = nxt[i];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
      refr <= '0;
      spike <= '0;
      winner <= '0;
      winner_valid <= 1'b0;
    end else begin
      spike <= '0;
      winner_valid <= 1'b0;
      if (in_valid) begin
        for (int i = 0; i < N_NEURONS; i++) begin
          if (refr[i] != '0) begin
            state[i] <= '0;
            refr[i] <= refr[i] - 1'b1;
          end else if (found && best == IW'(i)) begin
            state[i] <= '0;
            refr[i] <= RW'(REFRACT);
          end else begin
            state[i] <= found ? dec[i] : nxt[i];
          end
        end
        if (found) begin
          spike <= {{(N_NEURONS-1){1'b0}}, 1'b1} << best;
          winner <= best;
          winner_valid <= 1'b1;
        end
      end
    end
  end
  assign probe_state = int'(probe_sel) < N_NEURONS ? state[probe_sel] : '0;
endmodule

// File: tb/tb_wta_lif_array.sv
// tb_wta_lif_array: randomized scoreboard bench for wta_lif_array against a behavioural neuron model
module tb_wta_lif_array;
  localparam int N = 4;
  localparam int W = 8;
  localparam int LS = 1;
  localparam int REFRACT = 2;
  typedef struct {
    logic [N-1:0] spike;
    logic [1:0]   winner;
    logic         wv;
    logic [W-1:0] probe;
  } rec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [N*W-1:0] current = '0;
  logic [W-1:0] threshold = '0;
  logic [W-1:0] inhibit = '0;
  logic [1:0] probe_sel = '0;
  logic [N-1:0] spike;
  logic [1:0] winner;
  logic winner_valid;
  logic [W-1:0] probe_state;
  rec_t q[$];
  int vectors = 0;
  int errors = 0;
  int st[N];
  int rf[N];
  int win = 0;
  wta_lif_array #(.N_NEURONS(N), .W(W), .LEAK_SHIFT(LS), .REFRACT(REFRACT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .current(current),
    .threshold(threshold), .inhibit(inhibit), .probe_sel(probe_sel),
    .spike(spike), .winner(winner), .winner_valid(winner_valid), .probe_state(probe_state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      st[i] = 0;
      rf[i] = 0;
    end
    win = 0;
  endtask
  task automatic drive(input bit v, input int c0, input int c1, input int c2, input int c3,
                       input int thr, input int inh, input int ps);
    int cur[N];
    int nx[N];
    int best;
    rec_t r;
    @(negedge clk);
    cur[0] = c0; cur[1] = c1; cur[2] = c2; cur[3] = c3;
    in_valid = v;
    current = {W'(c3), W'(c2), W'(c1), W'(c0)};
    threshold = W'(thr);
    inhibit = W'(inh);
    probe_sel = 2'(ps);
    best = -1;
    if (v) begin
      for (int i = 0; i < N; i++) begin
        nx[i] = st[i] - st[i] / (1 << LS) + cur[i];
        if (nx[i] > 255) nx[i] = 255;
        if (rf[i] == 0 && nx[i] >= thr && (best < 0 || nx[i] > nx[best])) best = i;
      end
      for (int i = 0; i < N; i++) begin
        if (rf[i] != 0) begin
          st[i] = 0;
          rf[i] = rf[i] - 1;
        end else if (i == best) begin
          st[i] = 0;
          rf[i] = REFRACT;
        end else if (best >= 0) begin
          st[i] = nx[i] > inh ? nx[i] - inh : 0;
        end else begin
          st[i] = nx[i];
        end
      end
      if (best >= 0) win = best;
    end
    r.spike = best >= 0 ? N'(1 << best) : '0;
    r.winner = 2'(win);
    r.wv = best >= 0;
    r.probe = W'(st[ps]);
    q.push_back(r);
  endtask
  task automatic reset_pulse();
    rec_t z;
    @(negedge clk);
    in_valid = 1'b1;
    current = {$urandom, $urandom};
    threshold = W'($urandom_range(0, 255));
    inhibit = W'($urandom);
    probe_sel = 2'($urandom);
    z.spike = '0; z.winner = '0; z.wv = 1'b0; z.probe = '0;
    q.push_back(z);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", int'({spike, winner, winner_valid, probe_state}), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    q.push_back(z);
    drive(0, 0, 0, 0, 0, 200, 50, 0);
  endtask
  initial begin
    rec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (spike !== e.spike || winner !== e.winner || winner_valid !== e.wv || probe_state !== e.probe) begin
          errors++;
          $display("FAIL scoreboard: got spike=%b winner=%0d wv=%b probe=%0d expected spike=%b winner=%0d wv=%b probe=%0d at %0t",
                   spike, winner, winner_valid, probe_state, e.spike, e.winner, e.wv, e.probe, $time);
        end
      end
    end
  end
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 200, 50, 0);
    drive(1, 150, 0, 0, 0, 200, 50, 0);
    @(negedge clk);
    chk("single_step1_probe0", int'(probe_state), 150);
    in_valid = 1'b0;
    drive(1, 150, 0, 0, 0, 200, 50, 0);
    @(negedge clk);
    chk("single_step2_spike", int'({spike, winner, winner_valid}), 7'b0001_00_1);
    chk("single_step2_probe0", int'(probe_state), 0);
    reset_pulse();
    drive(1, 120, 130, 0, 0, 200, 50, 0);
    drive(1, 120, 130, 0, 0, 200, 50, 1);
    @(negedge clk);
    chk("compete_step2_state1", int'(probe_state), 195);
    in_valid = 1'b0;
    drive(1, 120, 130, 0, 0, 200, 50, 0);
    @(negedge clk);
    chk("compete_step3_spike", int'({spike, winner, winner_valid}), 7'b0010_01_1);
    chk("compete_step3_state0", int'(probe_state), 160);
    in_valid = 1'b0;
    drive(1, 0, 255, 0, 0, 200, 50, 1);
    drive(0, 0, 255, 0, 0, 200, 50, 1);
    drive(0, 0, 255, 0, 0, 200, 50, 1);
    drive(1, 0, 255, 0, 0, 200, 50, 1);
    drive(0, 0, 255, 0, 0, 200, 50, 1);
    drive(1, 0, 255, 0, 0, 200, 50, 1);
    @(negedge clk);
    chk("refract_reintegrate_spike", int'(spike), 4'b0010);
    in_valid = 1'b0;
    reset_pulse();
    drive(1, 0, 0, 150, 150, 200, 50, 3);
    drive(1, 0, 0, 150, 150, 200, 50, 3);
    @(negedge clk);
    chk("tie_winner", int'({spike, winner}), 6'b0100_10);
    chk("tie_state3", int'(probe_state), 175);
    in_valid = 1'b0;
    reset_pulse();
    drive(1, 200, 0, 0, 0, 255, 50, 0);
    drive(1, 255, 0, 0, 0, 255, 50, 0);
    @(negedge clk);
    chk("saturate_fire", int'({spike, winner_valid}), 5'b0001_1);
    in_valid = 1'b0;
    reset_pulse();
    drive(1, 0, 0, 0, 0, 0, 50, 0);
    drive(1, 0, 0, 0, 0, 0, 50, 0);
    @(negedge clk);
    chk("thr0_step2", int'(spike), 4'b0010);
    in_valid = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 50, 0);
    @(negedge clk);
    chk("thr0_step3", int'(spike), 4'b0100);
    in_valid = 1'b0;
    repeat (3) drive(0, 0, 0, 0, 0, 0, 50, 0);
    reset_pulse();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) reset_pulse();
      else drive($urandom_range(0, 9) < 7, $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 9) == 0 ? 0 : $urandom_range(100, 255),
                 $urandom_range(0, 255), $urandom_range(0, 3));
    end
    drive(0, 0, 0, 0, 0, 200, 50, 0);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/wta_lif_array.md
# wta_lif_array

Parametrised winner-take-all array of leaky integrate-and-fire (LIF) neurons with lateral inhibition and per-neuron refractory periods. It replaces the fixed single-network instance in the chip top-level: current inputs come from the pad/register interface, and the spike vector and winner index drive the bidirectional outputs. A probe mux exposes any neuron's membrane state on the 8-bit display outputs.

## Interface
- N_NEURONS, 4: number of neurons; ≥2.
- W, 8: membrane state, current, threshold and inhibit width in bits.
- LEAK_SHIFT, 1: leak per step is `state >> LEAK_SHIFT`; range 1..W-1.
- REFRACT, 2: refractory length in steps after a spike; 0 disables refractoriness.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  one integration step is taken in each cycle where this is high.
- current  in  N_NEURONS*W  packed unsigned input currents; neuron i uses bits [i*W +: W].
- threshold  in  W  firing threshold, unsigned.
- inhibit  in  W  amount subtracted from every non-winning neuron when a spike occurs.
- probe_sel  in  clog2(N_NEURONS)  neuron index for probe_state.
- spike  out  N_NEURONS  one-hot spike vector; one-cycle pulse.
- winner  out  clog2(N_NEURONS)  index of the last neuron to spike.
- winner_valid  out  1  one-cycle pulse, coincident with any spike.
- probe_state  out  W  membrane state of neuron probe_sel.

## Operation
- **Per-neuron registers:** state[i] (W bits) and refr[i] (clog2(REFRACT+1) bits).
- **Step** (in_valid=1). For each neuron i with refr[i]==0, compute in W+2 bits:
  - next[i] = state[i] − (state[i] >> LEAK_SHIFT) + current[i].
  - Saturate next[i] at 2^W−1.
  - Neuron i is a candidate if next[i] ≥ threshold (unsigned).
- **Refractory neurons** (refr[i]≠0) are never candidates. They hold state 0 and decrement refr[i] by 1 on each step.
- **Winner selection:**
  - The winner is the candidate with the largest next[i]; ties go to the lowest index.
  - At most one spike bit is set per step.
- **With a winner w:**
  - spike[w]=1, winner=w, winner_valid=1.
  - state[w]←0 and refr[w]←REFRACT.
  - Every other non-refractory neuron gets state←max(next[i] − inhibit, 0). Non-winning candidates get the same update and do not spike.
- **Without a winner:** every non-refractory neuron gets state←next[i]. spike=0 and winner_valid=0, and winner holds its value.
- **No step** (in_valid=0): all state and refr registers hold, and spike and winner_valid are 0.
- **threshold=0:** every non-refractory neuron is a candidate, so a spike occurs on every step while at least one neuron is non-refractory.
- **All neurons refractory:** there is no spike; the counters still decrement.
- **probe_sel ≥ N_NEURONS:** probe_state=0.

## Timing
- **Reset** (asynchronous, rst_n=0): all state=0, all refr=0, spike=0, winner=0, winner_valid=0. probe_state therefore reads 0.
- **Latency:** spike, winner and winner_valid are registered. They appear in the cycle after the in_valid cycle that caused them and are held for exactly one cycle.
- **Back-to-back steps:** in_valid may be high every cycle, giving a throughput of one step per cycle.
- **probe_state** is a combinational mux of the state registers. It reflects a step's result in the cycle after that step.
- **Input sampling:** threshold, inhibit and current are sampled only in step cycles. They may change on any cycle.
- **Reset mid-step:** reset overrides everything. No partial update survives, and no spike pulse is emitted after reset deasserts.

## Test plan
All scenarios use the defaults (N=4, W=8, LEAK_SHIFT=1, REFRACT=2), inhibit=50 and threshold=200 unless noted.
1. **Reset:** drive random inputs, assert rst_n=0 mid-run → all outputs 0 asynchronously; after release with in_valid=0, all outputs stay 0.
2. **Single integration:** current0=150, others 0, two steps → probe0 reads 150 after step 1. After step 2: spike=0001, winner=0, winner_valid=1 for one cycle, probe0=0.
3. **Competition:** current0=120, current1=130, three steps.
   - After step 2: states 180 and 195, no spike.
   - After step 3: spike=0010, winner=1, state1=0, state0=210−50=160.
4. **Tie and saturation:**
   - Tie: current2=current3=150, two steps → spike=0100, winner=2, state3=225−50=175.
   - Saturation: state0=200, current0=255, threshold=255 → next saturates to 255, and neuron 0 fires.
5. **Refractory:** after scenario 3, hold current1=255 → neuron 1 reads 0 and cannot spike for 2 steps, then integrates. Also apply in_valid=0 cycles in between → refr and state hold.
6. **threshold=0 and idle:**
   - threshold=0, all currents 0 → neuron 0 spikes on step 1, neuron 1 on step 2, then neuron 2 on step 3.
   - in_valid=0 → no spikes, registers hold.
